wb_merge: RTL and testbench
===========================

Name: wb_merge

Overview:
- Write-port driver for the 32x32 register file. It produces the single regwr/rw/busw write interface.
- Merges two sources onto that port:
  - Primary writeback from the single-cycle datapath, which always has priority.
  - Auxiliary long-latency results (multi-cycle mul/div, delayed load return) arriving on a valid/ready handshake.
- Auxiliary results are buffered in a small FIFO and drained on idle primary cycles.
- Pending-write flags let control stall reads of registers whose auxiliary write has not yet landed.

Parameters:
- DEPTH, 4, auxiliary FIFO entries; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width.
- DW, 32, data width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- main_wr  input  1  primary writeback enable this cycle
- main_rw  input  5  primary destination register
- main_busw  input  DW  primary write data
- aux_valid  input  1  auxiliary result valid
- aux_ready  output  1  auxiliary result can be accepted
- aux_rw  input  5  auxiliary destination register
- aux_busw  input  DW  auxiliary write data
- regwr  output  1  register file write enable
- rw  output  5  register file write address
- busw  output  DW  register file write data
- ra  input  5  read address A, for the pending check
- rb  input  5  read address B, for the pending check
- pend_a  output  1  ra has a buffered, unwritten auxiliary write
- pend_b  output  1  rb has a buffered, unwritten auxiliary write
- count  output  AW+1  number of buffered entries

Behaviour:
- Reset: rst is synchronous and active-high on clk.
  - At the edge: FIFO emptied, pointers and count cleared to 0.
  - While rst is high: regwr=0, aux_ready=0, pend_a=pend_b=0.
  - Reset mid-operation discards all buffered entries; they are never written.
- Handshake:
  - aux_ready = !rst && (count < DEPTH).
  - Transfer occurs when aux_valid && aux_ready.
  - A full FIFO refuses input even in a cycle where it also pops; no same-cycle enqueue on full.
  - Producer holds aux_rw/aux_busw stable while valid && !ready.
- A transfer with aux_rw==0 completes the handshake but is discarded: not enqueued, count unchanged.
- Write-port arbitration is combinational within a cycle, priority order:
  1. main_wr=1: regwr=1, rw=main_rw, busw=main_busw; no pop.
  2. else count>0: regwr=1, rw/busw = FIFO head; head pops at the clock edge.
  3. else regwr=0; rw and busw are don't-care, driven 0.
- main_wr with main_rw==0 is passed through unchanged; the register file ignores writes to register 0.
- Latency:
  - An auxiliary entry accepted in cycle N is written no earlier than cycle N+1. There is no empty-FIFO bypass.
  - Starvation is the control unit's concern; no fairness is enforced.
- Ordering:
  - FIFO entries drain strictly in arrival order.
  - A primary write to a register with a pending auxiliary write overtakes it.
  - Control must stall an instruction that writes or reads a pending register, using pend_a/pend_b.
- Pending flags:
  - pend_a = (ra!=0) && some valid FIFO entry has rw==ra; pend_b likewise for rb.
  - Combinational over stored entries only; an entry being accepted this cycle is not included.
  - The head entry popping this cycle still reports pending in that cycle.
- Count update:
  - count(next) = count + push - pop, where push = transfer && aux_rw!=0 and pop = !main_wr && count>0.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.

Decomposition:
- Shared package holds:
  - Register-index width constant REG_AW=5.
  - Data width constant.
  - The zero-register index constant.
- One sub-module is natural: wb_fifo (DEPTH x (5+DW) storage, head/tail pointers, count, plus a per-entry valid/rw vector exported for the pending compare).
- Arbitration and the pending compare stay in wb_merge.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst 2 cycles, then release.
  - Required: regwr=0, count=0, aux_ready=1, pend_a=0.
  - Stimulus: raise rst mid-drain with 3 entries buffered.
  - Required: next cycle count=0, no further regwr from those entries.
- Aux alone:
  - Stimulus: aux_valid with aux_rw=5, aux_busw=0x12345678 in cycle N, main idle.
  - Required: count=1 and pend_a=1 (ra=5) in N+1; regwr=1, rw=5, busw=0x12345678 in N+1; count=0 in N+2.
- Primary priority:
  - Stimulus: 2 aux entries buffered (r3=0xA, r4=0xB); main_wr high 3 cycles (r7=0x1, 0x2, 0x3).
  - Required: regwr carries r7 values for those 3 cycles, then r3=0xA, then r4=0xB, in that order.
- Full FIFO:
  - Stimulus: 4 aux pushes while main_wr is held high.
  - Required: count=4, aux_ready=0; a 5th aux_valid is held off until main_wr drops and one pop occurs; then aux_ready=1 the following cycle.
- Zero-register discard:
  - Stimulus: aux transfer with aux_rw=0, aux_busw=0xDEAD.
  - Required: handshake completes, count stays 0, no regwr, pend_a=0 with ra=0.
- Simultaneous push/pop with wrap:
  - Stimulus: stream 10 aux entries (r1..r10, data = register index) with main idle.
  - Required: each written exactly once in order; count never exceeds 1; pointers wrap correctly past DEPTH.

Source files
------------

// File: rtl/wb_merge_pkg.sv
// Shared constants for the register-file write-port merge logic.
package wb_merge_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding auxiliary register writes until the write port is free.
// Each slot carries a valid bit and its destination register so the parent can
// check whether a read address still has an unwritten result in flight.
module wb_fifo
    import wb_merge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [REG_AW-1:0]             push_rw,
    input  logic [DW-1:0]                 push_data,
    output logic [REG_AW-1:0]             head_rw,
    output logic [DW-1:0]                 head_data,
    output logic [AW:0]                   count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  entry_rw
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [DW-1:0] data_mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // A full buffer never accepts, an empty one never releases.
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);

    assign head_rw   = entry_rw[head];
    assign head_data = data_mem[head];

    // Pointers, occupancy and per-slot valid bits; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            if (do_pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; stale slots are masked by entry_valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entry_rw[tail] <= push_rw;
            data_mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/wb_merge.sv
// Register-file write-port driver: the single-cycle datapath writeback always wins,
// long-latency auxiliary results wait in a small buffer and drain on idle cycles.
// Pending flags expose buffered destinations so control can stall dependent reads.
module wb_merge
    import wb_merge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              main_wr,
    input  logic [REG_AW-1:0] main_rw,
    input  logic [DW-1:0]     main_busw,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [REG_AW-1:0] aux_rw,
    input  logic [DW-1:0]     aux_busw,
    output logic              regwr,
    output logic [REG_AW-1:0] rw,
    output logic [DW-1:0]     busw,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic              pend_a,
    output logic              pend_b,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic                         push;
    logic                         pop;
    logic                         fifo_nonempty;
    logic [REG_AW-1:0]            head_rw;
    logic [DW-1:0]                head_data;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][REG_AW-1:0] entry_rw;

    assign fifo_nonempty = (count != '0);
    assign aux_ready     = !rst && (count != FULL_CNT);

    // Writes to register 0 finish the handshake but are dropped instead of buffered.
    assign push = aux_valid && aux_ready && (aux_rw != REG_ZERO);
    assign pop  = !rst && !main_wr && fifo_nonempty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .push_rw     (aux_rw),
        .push_data   (aux_busw),
        .head_rw     (head_rw),
        .head_data   (head_data),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_rw    (entry_rw)
    );

    // Write-port arbitration: primary first, then buffer head, otherwise idle at zero.
    always_comb begin
        regwr = 1'b0;
        rw    = REG_ZERO;
        busw  = '0;
        if (!rst) begin
            if (main_wr) begin
                regwr = 1'b1;
                rw    = main_rw;
                busw  = main_busw;
            end else if (fifo_nonempty) begin
                regwr = 1'b1;
                rw    = head_rw;
                busw  = head_data;
            end
        end
    end

    // Pending compare over stored entries only; the head popping this cycle still counts.
    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rw[i] == ra)) pend_a = 1'b1;
            if (entry_valid[i] && (entry_rw[i] == rb)) pend_b = 1'b1;
        end
        if (rst || (ra == REG_ZERO)) pend_a = 1'b0;
        if (rst || (rb == REG_ZERO)) pend_b = 1'b0;
    end

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge with a queue scoreboard of buffered auxiliary writes.
module tb_wb_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        main_wr;
    logic [4:0]  main_rw;
    logic [31:0] main_busw;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rw;
    logic [31:0] aux_busw;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        pend_a;
    logic        pend_b;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } entry_t;

    entry_t model_q[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    wb_merge #(.DEPTH(4), .AW(2), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .main_wr   (main_wr),
        .main_rw   (main_rw),
        .main_busw (main_busw),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_rw    (aux_rw),
        .aux_busw  (aux_busw),
        .regwr     (regwr),
        .rw        (rw),
        .busw      (busw),
        .ra        (ra),
        .rb        (rb),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic m_wr, input logic [4:0] m_rw, input logic [31:0] m_data,
                                 input logic a_valid, input logic [4:0] a_rw, input logic [31:0] a_data);
        main_wr   = m_wr;
        main_rw   = m_rw;
        main_busw = m_data;
        aux_valid = a_valid;
        aux_rw    = a_rw;
        aux_busw  = a_data;
    endtask

    // Compare every output against the scoreboard at the falling edge.
    task automatic checkOutput();
        logic        exp_wr;
        logic [4:0]  exp_rw;
        logic [31:0] exp_busw;
        logic        exp_pa;
        logic        exp_pb;
        @(negedge clk);
        exp_wr   = 1'b0;
        exp_rw   = 5'd0;
        exp_busw = 32'd0;
        exp_pa   = 1'b0;
        exp_pb   = 1'b0;
        if (!rst) begin
            if (main_wr) begin
                exp_wr   = 1'b1;
                exp_rw   = main_rw;
                exp_busw = main_busw;
            end else if (model_q.size() > 0) begin
                exp_wr   = 1'b1;
                exp_rw   = model_q[0].rw;
                exp_busw = model_q[0].data;
            end
            foreach (model_q[i]) begin
                if (ra != 5'd0 && model_q[i].rw == ra) exp_pa = 1'b1;
                if (rb != 5'd0 && model_q[i].rw == rb) exp_pb = 1'b1;
            end
        end
        check("regwr", {31'd0, regwr}, {31'd0, exp_wr});
        check("rw", {27'd0, rw}, {27'd0, exp_rw});
        check("busw", busw, exp_busw);
        check("count", {29'd0, count}, 32'(model_q.size()));
        check("aux_ready", {31'd0, aux_ready}, {31'd0, (!rst && model_q.size() < 4)});
        check("pend_a", {31'd0, pend_a}, {31'd0, exp_pa});
        check("pend_b", {31'd0, pend_b}, {31'd0, exp_pb});
    endtask

    // Update the scoreboard for the coming edge, then move just past it.
    task automatic advance();
        bit do_pop;
        bit do_push;
        do_pop  = !rst && !main_wr && (model_q.size() > 0);
        do_push = !rst && aux_valid && (model_q.size() < 4) && (aux_rw != 5'd0);
        if (rst) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{rw: aux_rw, data: aux_busw});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stepCycle();
        checkOutput();
        advance();
    endtask

    initial begin
        rst = 1'b1;
        ra  = 5'd0;
        rb  = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;

        // Reset held for two cycles, then idle.
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkOutput();
        check("idle_regwr", {31'd0, regwr}, 32'd0);
        check("idle_count", {29'd0, count}, 32'd0);
        check("idle_ready", {31'd0, aux_ready}, 32'd1);
        check("idle_pend_a", {31'd0, pend_a}, 32'd0);
        advance();

        // Single auxiliary write with idle primary.
        ra = 5'd5;
        rb = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234_5678);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput();
        check("aux_cnt1", {29'd0, count}, 32'd1);
        check("aux_pend_a", {31'd0, pend_a}, 32'd1);
        check("aux_regwr", {31'd0, regwr}, 32'd1);
        check("aux_rw", {27'd0, rw}, 32'd5);
        check("aux_busw", busw, 32'h1234_5678);
        advance();
        checkOutput();
        check("aux_cnt0", {29'd0, count}, 32'd0);
        advance();

        // Register-zero transfer is accepted and dropped.
        ra = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_DEAD);
        checkOutput();
        check("zero_ready", {31'd0, aux_ready}, 32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput();
        check("zero_count", {29'd0, count}, 32'd0);
        check("zero_regwr", {31'd0, regwr}, 32'd0);
        check("zero_pend_a", {31'd0, pend_a}, 32'd0);
        advance();

        // Primary priority: buffer r3/r4 under primary traffic, then three r7 writes.
        ra = 5'd3;
        rb = 5'd4;
        applyStimulus(1'b1, 5'd6, 32'h55, 1'b1, 5'd3, 32'hA);
        stepCycle();
        applyStimulus(1'b1, 5'd6, 32'h56, 1'b1, 5'd4, 32'hB);
        stepCycle();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 5'd7, 32'(k), 1'b0, 5'd0, 32'd0);
            checkOutput();
            check("prio_main_rw", {27'd0, rw}, 32'd7);
            check("prio_main_busw", busw, 32'(k));
            advance();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput();
        check("prio_r3", {27'd0, rw}, 32'd3);
        check("prio_r3_data", busw, 32'hA);
        advance();
        checkOutput();
        check("prio_r4", {27'd0, rw}, 32'd4);
        check("prio_r4_data", busw, 32'hB);
        advance();
        stepCycle();

        // Fill the buffer under primary traffic, then hold off a fifth entry.
        ra = 5'd11;
        rb = 5'd15;
        for (int k = 0; k < 4; k++)
        begin
            applyStimulus(1'b1, 5'd6, 32'h100 + 32'(k), 1'b1, 5'(11 + k), 32'hB0 + 32'(k));
            stepCycle();
        end
        applyStimulus(1'b1, 5'd6, 32'h200, 1'b1, 5'd15, 32'hBF);
        for (int k = 0; k < 2; k++) begin
            checkOutput();
            check("full_count", {29'd0, count}, 32'd4);
            check("full_ready", {31'd0, aux_ready}, 32'd0);
            advance();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hBF);
        checkOutput();
        check("full_pop_ready", {31'd0, aux_ready}, 32'd0);
        check("full_pop_rw", {27'd0, rw}, 32'd11);
        advance();
        checkOutput();
        check("full_reopen", {31'd0, aux_ready}, 32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 6; k++) stepCycle();

        // Stream ten entries with idle primary; occupancy stays at one and pointers wrap.
        ra = 5'd4;
        rb = 5'd9;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'(k));
            checkOutput();
            check("stream_cnt_le1", {31'd0, (count <= 3'd1)}, 32'd1);
            advance();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput();
        check("stream_last_rw", {27'd0, rw}, 32'd10);
        advance();
        stepCycle();

        // Reset while three entries are still buffered discards them.
        ra = 5'd21;
        rb = 5'd22;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd6, 32'h300 + 32'(k), 1'b1, 5'(20 + k), 32'hC0 + 32'(k));
            stepCycle();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        rst = 1'b1;
        checkOutput();
        check("rst_mid_regwr", {31'd0, regwr}, 32'd0);
        advance();
        rst = 1'b0;
        checkOutput();
        check("rst_mid_count", {29'd0, count}, 32'd0);
        check("rst_mid_pend", {31'd0, pend_a}, 32'd0);
        advance();
        for (int k = 0; k < 4; k++) begin
            checkOutput();
            check("rst_no_write", {31'd0, regwr}, 32'd0);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
